// File: rtl/stackq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stackq_pkg
// Purpose  : Shared constants and helpers for the stack/queue buffer.
//            MODE_STACK / MODE_QUEUE encode the operating mode held in the
//            buffer's mode register. cnt_width() gives the width of an entry
//            counter able to hold 0..depth inclusive.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stackq_pkg;

  localparam logic MODE_STACK = 1'b0;
  localparam logic MODE_QUEUE = 1'b1;

  // Counter must represent DEPTH itself (full), hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stackq_mem.sv
`default_nettype none
// ============================================================================
// Module   : stackq_mem
// Purpose  : DEPTH x WIDTH storage array. One synchronous write port, one
//            asynchronous read port, no reset (contents survive reset).
// Ports    : clk      - write clock
//            we_i     - write enable
//            waddr_i  - write address
//            wdata_i  - write data
//            raddr_i  - read address
//            rdata_o  - read data (combinational from raddr_i)
// Revision : 1.0 - initial release
// ============================================================================
module stackq_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/stack_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stack_queue_buffer
// Purpose  : Dual-mode buffer: LIFO stack (sel=0) or FIFO queue (sel=1).
//            All outputs come from registered state only; results appear
//            one cycle after the triggering edge.
// Config   : define STACKQ_ERR_FLAGS_EN to build the sticky overflow /
//            underflow flags; otherwise both flags read 0 and clr_err is
//            ignored (illegal push/pop are still dropped).
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            sel       - mode select (0 stack, 1 queue)
//            push      - write data_in
//            pop       - remove current output entry
//            flush     - discard all entries, clear error flags
//            clr_err   - clear sticky error flags
//            data_in   - write data
//            data_out  - stack top / queue head, 0 when empty
//            count     - number of valid entries
//            empty     - count == 0
//            full      - count == DEPTH
//            overflow  - sticky: push attempted while full
//            underflow - sticky: pop attempted while empty
// Revision : 1.0 - initial release
// ============================================================================
module stack_queue_buffer
  import stackq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic          mode_q,   mode_d;
  logic [CW-1:0] count_q,  count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic             w_empty;
  logic             w_full;
  logic             w_mode_sw;
  logic             w_acc_push;
  logic             w_acc_pop;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [AW-1:0]    w_top_addr;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_waddr;
  logic [AW-1:0]    w_mem_raddr;
  logic [WIDTH-1:0] w_mem_rdata;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == CNT_FULL);
  assign w_mode_sw  = (sel != mode_q);
  assign w_top_addr = AW'(count_q - CW'(1));

  // Push+pop while full is legal (replace / dequeue+enqueue); push+pop while
  // empty degenerates to a plain push.
  assign w_acc_push = push & (~w_full | pop);
  assign w_acc_pop  = pop & ~w_empty;
  assign w_ovf_evt  = push & ~pop & w_full;
  assign w_unf_evt  = pop & ~push & w_empty;

  always_comb begin
    mode_d      = mode_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    w_mem_we    = 1'b0;
    w_mem_waddr = wr_ptr_q;

    if (w_mode_sw) begin
      mode_d   = sel;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      w_mem_we = w_acc_push;
      if (mode_q == MODE_STACK) begin
        // Simultaneous pop turns the push into an overwrite of the top.
        w_mem_waddr = w_acc_pop ? w_top_addr : count_q[AW-1:0];
      end else begin
        w_mem_waddr = wr_ptr_q;
        if (w_acc_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_acc_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (w_acc_push && !w_acc_pop) begin
        count_d = count_q + CW'(1);
      end else if (w_acc_pop && !w_acc_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= sel;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mode_q   <= mode_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef STACKQ_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error outranks clr_err in the same cycle; a mode switch leaves
  // the flags untouched even if flush is also asserted.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (w_mode_sw) begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end else if (flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = w_ovf_evt | (ovf_q & ~clr_err);
      unf_d = w_unf_evt | (unf_q & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic w_unused_err;
  assign w_unused_err = &{1'b0, clr_err, w_ovf_evt, w_unf_evt};
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

  assign w_mem_raddr = (mode_q == MODE_QUEUE) ? rd_ptr_q : w_top_addr;

  stackq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_mem_we),
    .waddr_i (w_mem_waddr),
    .wdata_i (data_in),
    .raddr_i (w_mem_raddr),
    .rdata_o (w_mem_rdata)
  );

  // Masking on empty keeps stale memory (which survives reset) off the bus.
  assign data_out = w_empty ? '0 : w_mem_rdata;
  assign count    = count_q;
  assign empty    = w_empty;
  assign full     = w_full;

endmodule
`default_nettype wire
